// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX sample packetizer.
// PKT_CHECKSUM_EN selects the 5-byte packet with trailing checksum.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_BUSY
    } tx_state_t;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] data;
    } sample_t;

    localparam logic [2:0] IDX_SYNC = 3'd0;
    localparam logic [2:0] IDX_CH   = 3'd1;
    localparam logic [2:0] IDX_MSB  = 3'd2;
    localparam logic [2:0] IDX_LSB  = 3'd3;

`ifdef PKT_CHECKSUM_EN
    localparam logic [2:0] IDX_CHK  = 3'd4;
    localparam int         PKT_LEN  = 5;

    function automatic logic [7:0] pkt_chk(input sample_t s);
        return {6'b0, s.ch} ^ s.data[15:8] ^ s.data[7:0];
    endfunction
`else
    localparam int         PKT_LEN  = 4;
`endif

    localparam logic [2:0] LAST_IDX = 3'(PKT_LEN - 1);
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_tx_packetizer_sample_fifo.sv
// Synchronous sample FIFO with registered read data.
// Pointers wrap naturally because DEPTH is a power of two.
module sample_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  sample_t                 wr_data,
    input  logic                    pop,
    output sample_t                 rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    sample_t          mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_packetizer.sv
// Frames buffered hydrophone samples into byte packets for the UART TX.
// Define PKT_CHECKSUM_EN to append an XOR checksum byte to each packet.
module uart_tx_packetizer
    import uart_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
    input  logic        UART_clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [1:0]  sample_ch,
    input  logic [15:0] sample_data,
    output logic        sample_ready,
    input  logic        TX_Ready,
    output logic        TX_en,
    output logic [7:0]  Word_To_Send,
    output logic        overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t   state;
    tx_state_t   state_nx;
    logic [2:0]  byte_idx;
    logic [2:0]  idx_nx;
    sample_t     pkt;
    sample_t     fifo_rd;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]  pkt_byte;

    assign sample_ready = (fifo_count != CW'(FIFO_DEPTH));

    sample_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (UART_clk),
        .reset   (reset),
        .push    (sample_valid && sample_ready),
        .wr_data ({sample_ch, sample_data}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge UART_clk) begin
        if (reset) begin
            state    <= IDLE;
            byte_idx <= '0;
            pkt      <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            byte_idx <= idx_nx;
            if (state == LOAD) begin
                pkt <= fifo_rd;
            end
            if (sample_valid && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // WAIT_BUSY guarantees one handshake per byte even if TX_Ready stays high
    always_comb begin
        state_nx = state;
        idx_nx   = byte_idx;
        fifo_pop = 1'b0;
        TX_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    idx_nx   = '0;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                state_nx = SEND;
            end
            SEND: begin
                TX_en = 1'b1;
                if (TX_Ready) begin
                    state_nx = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!TX_Ready) begin
                    if (byte_idx == LAST_IDX) begin
                        state_nx = IDLE;
                    end else begin
                        idx_nx   = byte_idx + 3'd1;
                        state_nx = SEND;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pkt_byte = 8'h00;
        case (byte_idx)
            IDX_SYNC: pkt_byte = SYNC_BYTE;
            IDX_CH:   pkt_byte = {6'b0, pkt.ch};
            IDX_MSB:  pkt_byte = pkt.data[15:8];
            IDX_LSB:  pkt_byte = pkt.data[7:0];
`ifdef PKT_CHECKSUM_EN
            IDX_CHK:  pkt_byte = pkt_chk(pkt);
`endif
            default:  pkt_byte = 8'h00;
        endcase
    end

    assign Word_To_Send = (state == SEND) ? pkt_byte : 8'h00;

endmodule

// File: tb/tb_uart_tx_packetizer.sv
// Self-checking bench for uart_tx_packetizer with a randomized TX model.
// Honours PKT_CHECKSUM_EN for the expected packet length and contents.
`timescale 1ns/1ps
module tb_uart_tx_packetizer;

`ifdef PKT_CHECKSUM_EN
    localparam int PLEN = 5;
`else
    localparam int PLEN = 4;
`endif

    logic        UART_clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [1:0]  sample_ch = '0;
    logic [15:0] sample_data = '0;
    logic        sample_ready;
    logic        TX_Ready = 1'b1;
    logic        TX_en;
    logic [7:0]  Word_To_Send;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int accept_cnt = 0;
    int tx_mode = 0;
    int tx_gap = 2;
    int busy = 0;
    int stab_viol = 0;
    logic prev_en = 1'b0;
    logic [7:0] prev_word = '0;

    uart_tx_packetizer dut (
        .UART_clk     (UART_clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .TX_Ready     (TX_Ready),
        .TX_en        (TX_en),
        .Word_To_Send (Word_To_Send),
        .overflow     (overflow)
    );

    always #5 UART_clk = ~UART_clk;

    // TX controller model: mode 0 drops Ready for tx_gap cycles per byte,
    // mode 1 holds Ready low, mode 2 holds Ready high.
    always @(posedge UART_clk) begin
        if (TX_en && TX_Ready) begin
            rx_q.push_back(Word_To_Send);
            accept_cnt++;
        end
        if (prev_en && TX_en && Word_To_Send != prev_word) begin
            stab_viol++;
        end
        prev_en   <= TX_en;
        prev_word <= Word_To_Send;
        case (tx_mode)
            1: TX_Ready <= 1'b0;
            2: TX_Ready <= 1'b1;
            default: begin
                if (TX_en && TX_Ready) begin
                    TX_Ready <= 1'b0;
                    busy     <= tx_gap;
                end else if (busy > 1) begin
                    busy <= busy - 1;
                end else begin
                    busy     <= 0;
                    TX_Ready <= 1'b1;
                end
            end
        endcase
    end

    function automatic void exp_sample(input logic [1:0] ch,
                                       input logic [15:0] d);
        exp_q.push_back(8'hA5);
        exp_q.push_back({6'b0, ch});
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
`ifdef PKT_CHECKSUM_EN
        exp_q.push_back({6'b0, ch} ^ d[15:8] ^ d[7:0]);
`endif
    endfunction

    task automatic push_one(input logic [1:0] ch, input logic [15:0] d);
        @(negedge UART_clk);
        sample_valid = 1'b1;
        sample_ch    = ch;
        sample_data  = d;
        @(posedge UART_clk);
    endtask

    task automatic stop_push();
        @(negedge UART_clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int limit);
        for (int c = 0; c < limit && rx_q.size() < n; c++) begin
            @(negedge UART_clk);
        end
    endtask

    task automatic test_reset();
        @(negedge UART_clk);
        reset = 1'b1;
        sample_valid = 1'b0;
        tx_mode = 0;
        @(posedge UART_clk);
        @(negedge UART_clk);
        checks++;
        if (TX_en !== 1'b0) begin
            errors++; $display("FAIL reset_tx_en got=%b want=0", TX_en);
        end
        checks++;
        if (Word_To_Send !== 8'h00) begin
            errors++; $display("FAIL reset_word got=%h want=00", Word_To_Send);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL reset_overflow got=%b want=0", overflow);
        end
        checks++;
        if (sample_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got=%b want=1", sample_ready);
        end
        reset = 1'b0;
        repeat (3) @(negedge UART_clk);
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_single_packet();
        logic [7:0] want [5];
        want[0] = 8'hA5; want[1] = 8'h02; want[2] = 8'h12;
        want[3] = 8'h34; want[4] = 8'h24;
        tx_gap = 50;
        rx_q.delete();
        push_one(2'd2, 16'h1234);
        stop_push();
        @(posedge UART_clk);
        @(negedge UART_clk);
        checks++;
        if (TX_en !== 1'b0) begin
            errors++; $display("FAIL latency_early got=%b want=0", TX_en);
        end
        @(posedge UART_clk);
        @(negedge UART_clk);
        checks++;
        if (TX_en !== 1'b1) begin
            errors++; $display("FAIL latency_n3 got=%b want=1", TX_en);
        end
        wait_bytes(PLEN, 2000);
        repeat (60) @(negedge UART_clk);
        checks++;
        if (rx_q.size() != PLEN) begin
            errors++;
            $display("FAIL single_len got=%0d want=%0d", rx_q.size(), PLEN);
        end
        for (int i = 0; i < PLEN && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== want[i]) begin
                errors++;
                $display("FAIL single_byte%0d got=%h want=%h", i, rx_q[i], want[i]);
            end
        end
        checks++;
        if (TX_en !== 1'b0) begin
            errors++; $display("FAIL single_idle got=%b want=0", TX_en);
        end
    endtask

    task automatic test_overflow();
        logic [1:0]  chs [18];
        logic [15:0] ds  [18];
        rx_q.delete();
        exp_q.delete();
        @(negedge UART_clk);
        tx_mode = 1;
        repeat (2) @(negedge UART_clk);
        for (int i = 0; i < 18; i++) begin
            chs[i] = 2'($urandom_range(0, 3));
            ds[i]  = 16'($urandom);
            if (i < 17) exp_sample(chs[i], ds[i]);
        end
        for (int i = 0; i < 18; i++) begin
            @(negedge UART_clk);
            if (i == 17) begin
                checks++;
                if (sample_ready !== 1'b0 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_full_pre ready=%b ovf=%b want ready=0 ovf=0",
                             sample_ready, overflow);
                end
            end
            sample_valid = 1'b1;
            sample_ch    = chs[i];
            sample_data  = ds[i];
            @(posedge UART_clk);
        end
        @(negedge UART_clk);
        sample_valid = 1'b0;
        checks++;
        if (sample_ready !== 1'b0) begin
            errors++; $display("FAIL ovf_ready got=%b want=0", sample_ready);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_flag got=%b want=1", overflow);
        end
        tx_gap  = int'($urandom_range(1, 3));
        tx_mode = 0;
        wait_bytes(exp_q.size(), 5000);
        repeat (30) @(negedge UART_clk);
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL ovf_len got=%0d want=%0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ovf_byte%0d got=%h want=%h", i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        int base;
        rx_q.delete();
        tx_gap = 5;
        push_one(2'($urandom_range(0, 3)), 16'($urandom));
        push_one(2'($urandom_range(0, 3)), 16'($urandom));
        push_one(2'($urandom_range(0, 3)), 16'($urandom));
        stop_push();
        for (int c = 0; c < 500 && !(rx_q.size() >= 1 && TX_en); c++) begin
            @(negedge UART_clk);
        end
        checks++;
        if (!(rx_q.size() >= 1 && TX_en === 1'b1)) begin
            errors++;
            $display("FAIL midrst_reach bytes=%0d en=%b want bytes>=1 en=1",
                     rx_q.size(), TX_en);
        end
        reset = 1'b1;
        @(posedge UART_clk);
        @(negedge UART_clk);
        base = rx_q.size();
        checks++;
        if (TX_en !== 1'b0) begin
            errors++; $display("FAIL midrst_en got=%b want=0", TX_en);
        end
        checks++;
        if (Word_To_Send !== 8'h00) begin
            errors++; $display("FAIL midrst_word got=%h want=00", Word_To_Send);
        end
        checks++;
        if (sample_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_ready got=%b want=1", sample_ready);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL midrst_ovf got=%b want=0", overflow);
        end
        reset = 1'b0;
        repeat (100) @(negedge UART_clk);
        checks++;
        if (rx_q.size() != base) begin
            errors++;
            $display("FAIL midrst_quiet got=%0d want=%0d", rx_q.size(), base);
        end
    endtask

    task automatic test_stuck_ready();
        int base;
        logic [1:0]  ch;
        logic [15:0] d;
        rx_q.delete();
        exp_q.delete();
        ch = 2'($urandom_range(0, 3));
        d  = 16'($urandom);
        exp_sample(ch, d);
        @(negedge UART_clk);
        tx_mode = 2;
        base = accept_cnt;
        push_one(ch, d);
        stop_push();
        for (int c = 0; c < 100 && accept_cnt == base; c++) begin
            @(negedge UART_clk);
        end
        repeat (20) @(negedge UART_clk);
        checks++;
        if (accept_cnt - base != 1) begin
            errors++;
            $display("FAIL stuck_count got=%0d want=1", accept_cnt - base);
        end
        checks++;
        if (TX_en !== 1'b0) begin
            errors++; $display("FAIL stuck_en got=%b want=0", TX_en);
        end
        tx_mode = 1;
        repeat (2) @(negedge UART_clk);
        tx_gap  = 2;
        tx_mode = 0;
        wait_bytes(PLEN, 1000);
        repeat (20) @(negedge UART_clk);
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stuck_len got=%0d want=%0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stuck_byte%0d got=%h want=%h", i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        rx_q.delete();
        exp_q.delete();
        tx_gap = int'($urandom_range(1, 4));
        for (int c = 0; c < 4; c++) begin
            d = 16'($urandom);
            exp_sample(2'(c), d);
            push_one(2'(c), d);
        end
        stop_push();
        wait_bytes(exp_q.size(), 2000);
        repeat (20) @(negedge UART_clk);
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_len got=%0d want=%0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d got=%h want=%h", i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random_stream();
        logic [1:0]  ch;
        logic [15:0] d;
        rx_q.delete();
        exp_q.delete();
        tx_gap = int'($urandom_range(1, 8));
        for (int s = 0; s < 12; s++) begin
            ch = 2'($urandom_range(0, 3));
            d  = 16'($urandom);
            exp_sample(ch, d);
            push_one(ch, d);
            stop_push();
            repeat ($urandom_range(0, 3)) @(negedge UART_clk);
        end
        wait_bytes(exp_q.size(), 5000);
        repeat (30) @(negedge UART_clk);
        checks++;
        if (rx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_len got=%0d want=%0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_byte%0d got=%h want=%h", i, rx_q[i], exp_q[i]);
            end
        end
        checks++;
        if (stab_viol != 0) begin
            errors++;
            $display("FAIL word_stable got=%0d changes want=0", stab_viol);
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_overflow();
        test_reset_mid_packet();
        test_stuck_ready();
        test_back_to_back();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_packetizer.md
# uart_tx_packetizer

Buffers hydrophone samples and frames each one into a fixed byte packet for the UART transmitter. It sits directly upstream of the UART TX datapath/controller. It feeds that block one byte at a time through the TX_en / TX_Ready / Word_To_Send handshake. All logic runs in the 5.76 MHz UART clock domain, so no CDC is needed on the TX side.

## Interface
- FIFO_DEPTH, 16: sample FIFO entries; power of two, minimum 2.
- SYNC_BYTE, 8'hA5: first byte of every packet.
- UART_clk  in  1  UART clock, 5.76 MHz; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_valid  in  1  a sample is offered this cycle.
- sample_ch  in  2  hydrophone channel of the offered sample.
- sample_data  in  16  sample value.
- sample_ready  out  1  FIFO can accept; equals !fifo_full (combinational from the occupancy count).
- TX_Ready  in  1  TX controller is idle and will latch Word_To_Send while TX_en is high.
- TX_en  out  1  Word_To_Send is valid.
- Word_To_Send  out  8  current packet byte.
- overflow  out  1  sticky; a sample was offered while the FIFO was full.

## Operation
- Push: a sample is written on any cycle with sample_valid && sample_ready. Each entry is {sample_ch, sample_data}, 18 bits.
- Packet byte order: SYNC_BYTE, {6'b0, ch}, data[15:8], data[7:0], then CHK (see Configuration).
- FSM states: IDLE, LOAD, SEND, WAIT_BUSY.
  - IDLE: if the FIFO is not empty, pop, clear byte_idx, go to LOAD. Otherwise stay.
  - LOAD: capture the FIFO read data into the packet register, go to SEND.
  - SEND: TX_en=1 and Word_To_Send=byte[byte_idx]. When TX_Ready=1, the byte counts as accepted; go to WAIT_BUSY.
  - WAIT_BUSY: TX_en=0. Wait for TX_Ready=0. Then, if byte_idx is the last byte, go to IDLE; else increment byte_idx and go to SEND.
- Exactly one TX_en && TX_Ready cycle occurs per byte. A TX_Ready that stays high after acceptance never causes a duplicate send.
- Word_To_Send is a mux of the packet register by byte_idx. It is held stable for the whole SEND state.
- Overflow: sample_valid && !sample_ready sets overflow. Only reset clears it. The offered sample is dropped.
- Simultaneous push and pop while full: sample_ready is already 0, so the push is rejected and overflow is set.
- Simultaneous push and pop while not full: both take effect and occupancy is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. Occupancy is a separate counter of width clog2(FIFO_DEPTH)+1.

## Timing
- Reset values, visible on the cycle after reset is sampled high: TX_en=0, Word_To_Send=8'h00, overflow=0, FSM=IDLE, FIFO empty, sample_ready=1.
- Latency: a sample pushed at edge N gives non-empty at N+1, pop in IDLE at N+1, LOAD at N+2, and TX_en high from edge N+3.
- Between bytes there is at least one TX_en=0 cycle (WAIT_BUSY).
- After the last byte, the next packet's TX_en rises no earlier than 3 cycles after TX_Ready falls.
- Reset mid-packet: the packet is aborted, the FIFO is flushed, and TX_en is 0 on the next cycle. The truncated packet is left on the line; the host resynchronises on SYNC_BYTE.

## Configuration
- PKT_CHECKSUM_EN defined: the packet is 5 bytes. CHK = {6'b0,ch} ^ data[15:8] ^ data[7:0]. SYNC_BYTE is excluded from CHK.
- PKT_CHECKSUM_EN undefined: the packet is 4 bytes, the last byte is data[7:0], and no checksum logic is built.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, LOAD, SEND, WAIT_BUSY);
  - the packet byte-index constants;
  - PKT_LEN, which is 5 or 4 depending on PKT_CHECKSUM_EN;
  - the default SYNC_BYTE.
- One sub-module: sample_fifo. It is a synchronous FIFO with registered read data, and exposes full, empty and count.

## Test plan
- Checksum on: push ch=2, data=16'h1234; a TX model drops TX_Ready for 50 cycles per byte. Required bytes: A5, 02, 12, 34, 24; TX_en first high at N+3.
- Checksum off (same stimulus): bytes A5, 02, 12, 34 only; FSM returns to IDLE after the 4th byte.
- Overflow: hold TX_Ready=0 and push 18 consecutive samples. Required: 16 accepted plus 1 already popped into LOAD/SEND; sample_ready=0; overflow=1 on the cycle after the 18th offer. Drained packets match the first 17 samples in order.
- TX_Ready stuck high after acceptance: exactly one TX_en && TX_Ready cycle occurs, then TX_en stays 0 and the FSM waits in WAIT_BUSY with no repeat byte.
- Reset during byte 2 of a packet, with 3 samples queued: next cycle TX_en=0, Word_To_Send=00, sample_ready=1, overflow=0; no bytes are sent afterwards without new pushes.
- Back-to-back: push ch0..ch3 on consecutive cycles. Required: four complete packets in channel order, with no interleaving and no dropped samples.
